// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU op codes and multiply FSM states.
package exec_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/exec_stage_p_alu_core.sv
// Combinational single-cycle ALU with signed-overflow flag.
// Latency: 0 (purely combinational).
// Backpressure: none; the caller decides when to capture the result.
module alu_core
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluctr,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SH_W-1:0]  shamt;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (aluctr)
            OP_ADD: begin
                res = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_SLT:  res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: res = WIDTH'(a < b);
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = $signed(a) >>> shamt;
            OP_LUI:  res = b << 16;
            // MUL is handled by the iterative unit in the stage; undefined codes yield 0
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/exec_stage_p.sv
// Execute stage: operand select, ALU, iterative shift-add multiply, registered EX/MEM output.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles for MUL.
// Backpressure: in_ready drops while a multiply runs or the output slot is held by !out_ready.
module exec_stage_p
    import exec_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REG_W  = 5,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             extop,
    input  logic             alusrc,
    input  logic [3:0]       aluctr,
    input  logic [WIDTH-1:0] busa,
    input  logic [WIDTH-1:0] busb,
    input  logic [15:0]      imm16,
    input  logic [REG_W-1:0] rd_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic [REG_W-1:0] rd_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] acc;
        logic [REG_W-1:0] rd;
    } mul_t;

    state_t           state;
    mul_t             mul;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] ext;
    logic [WIDTH-1:0] busc;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] acc_next;
    logic             accept;
    logic             slot_free;
    logic             is_mul;

    assign ext  = extop ? WIDTH'($signed(imm16)) : WIDTH'(imm16);
    assign busc = alusrc ? ext : busb;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == S_IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign is_mul    = (MUL_EN != 0) && (aluctr == OP_MUL);

    // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set
    assign acc_next = mul.acc + (mul.b[0] ? mul.a : '0);

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a      (busa),
        .b      (busc),
        .aluctr (aluctr),
        .res    (alu_res),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mul       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            rd_out    <= '0;
            busy      <= 1'b0;
        end else begin
            // A write below in the same cycle overrides this consume
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            mul.a   <= busa;
                            mul.b   <= busc;
                            mul.acc <= '0;
                            mul.rd  <= rd_in;
                            cnt     <= '0;
                            busy    <= 1'b1;
                            state   <= S_MUL;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            ovf       <= alu_ovf;
                            rd_out    <= rd_in;
                        end
                    end
                end
                S_MUL: begin
                    mul.acc <= acc_next;
                    mul.a   <= mul.a << 1;
                    mul.b   <= mul.b >> 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        if (slot_free) begin
                            out_valid <= 1'b1;
                            result    <= acc_next;
                            zero      <= (acc_next == '0);
                            ovf       <= 1'b0;
                            rd_out    <= mul.rd;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        result    <= mul.acc;
                        zero      <= (mul.acc == '0);
                        ovf       <= 1'b0;
                        rd_out    <= mul.rd;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_stage_p.sv
// Directed self-checking bench for exec_stage_p with hand-computed expectations.
module tb_exec_stage_p;
    import exec_pkg::*;

    localparam int WIDTH = 32;
    localparam int REG_W = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             extop;
    logic             alusrc;
    logic [3:0]       aluctr;
    logic [WIDTH-1:0] busa;
    logic [WIDTH-1:0] busb;
    logic [15:0]      imm16;
    logic [REG_W-1:0] rd_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic [REG_W-1:0] rd_out;
    logic             busy;

    int checks;
    int failures;

    exec_stage_p #(.WIDTH(WIDTH), .REG_W(REG_W), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .extop     (extop),
        .alusrc    (alusrc),
        .aluctr    (aluctr),
        .busa      (busa),
        .busb      (busb),
        .imm16     (imm16),
        .rd_in     (rd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .rd_out    (rd_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        src;
        logic [15:0] imm;
        logic [31:0] exp_res;
        logic        exp_ovf;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic ext, input logic [15:0] imm,
                         input logic [REG_W-1:0] rd);
        aluctr = op;
        busa   = a;
        busb   = b;
        alusrc = src;
        extop  = ext;
        imm16  = imm;
        rd_in  = rd;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive(OP_ADD, 32'd5, 32'd6, 1'b0, 1'b0, 16'h0, 5'd9);
        tick();
        tick();
        checks++;
        if ({out_valid, result, zero, ovf, rd_out, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: out_valid=%0b result=%h zero=%0b ovf=%0b rd_out=%0d busy=%0b, all required 0",
                     out_valid, result, zero, ovf, rd_out, busy);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_add_ovf();
        drive(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 16'h0, 5'd3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, result, ovf, zero, rd_out} !== {1'b1, 32'h8000_0000, 1'b1, 1'b0, 5'd3}) begin
            failures++;
            $display("FAIL add_ovf: valid=%0b result=%h ovf=%0b zero=%0b rd=%0d want 1 80000000 1 0 3",
                     out_valid, result, ovf, zero, rd_out);
        end
    endtask

    task automatic test_immediate();
        drive(OP_ADD, 32'd5, 32'hDEAD_BEEF, 1'b1, 1'b1, 16'hFFFF, 5'd1);
        in_valid = 1'b1;
        tick();
        checks++;
        if ({out_valid, result} !== {1'b1, 32'h0000_0004}) begin
            failures++;
            $display("FAIL imm_sext: valid=%0b result=%h want 1 00000004", out_valid, result);
        end
        // Second op accepted on the very next edge
        extop = 1'b0;
        rd_in = 5'd2;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, result, rd_out} !== {1'b1, 32'h0001_0004, 5'd2}) begin
            failures++;
            $display("FAIL imm_zext: valid=%0b result=%h rd=%0d want 1 00010004 2", out_valid, result, rd_out);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL imm_drain: out_valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_ops();
        vec_t v[12];
        v[0]  = '{OP_SUB,  32'd3,          32'd5,          1'b0, 16'h0,    32'hFFFF_FFFE, 1'b0};
        v[1]  = '{OP_SUB,  32'h8000_0000,  32'd1,          1'b0, 16'h0,    32'h7FFF_FFFF, 1'b1};
        v[2]  = '{OP_AND,  32'hF0F0_1234,  32'h0FF0_00FF,  1'b0, 16'h0,    32'h00F0_0034, 1'b0};
        v[3]  = '{OP_OR,   32'hF0F0_1234,  32'h0FF0_00FF,  1'b0, 16'h0,    32'hFFF0_12FF, 1'b0};
        v[4]  = '{OP_XOR,  32'hF0F0_1234,  32'h0FF0_00FF,  1'b0, 16'h0,    32'hFF00_12CB, 1'b0};
        v[5]  = '{OP_NOR,  32'hF0F0_1234,  32'h0FF0_00FF,  1'b0, 16'h0,    32'h000F_ED00, 1'b0};
        v[6]  = '{OP_SLT,  32'hF0F0_1234,  32'h0FF0_00FF,  1'b0, 16'h0,    32'h0000_0001, 1'b0};
        v[7]  = '{OP_SLTU, 32'hF0F0_1234,  32'h0FF0_00FF,  1'b0, 16'h0,    32'h0000_0000, 1'b0};
        v[8]  = '{OP_SLL,  32'h8000_0010,  32'h0000_0024,  1'b0, 16'h0,    32'h0000_0100, 1'b0};
        v[9]  = '{OP_SRL,  32'h8000_0010,  32'h0000_0024,  1'b0, 16'h0,    32'h0800_0001, 1'b0};
        v[10] = '{OP_SRA,  32'h8000_0010,  32'h0000_0024,  1'b0, 16'h0,    32'hF800_0001, 1'b0};
        v[11] = '{OP_LUI,  32'h0,          32'h0,          1'b1, 16'h1234, 32'h1234_0000, 1'b0};
        for (int i = 0; i < 12; i++) begin
            drive(v[i].op, v[i].a, v[i].b, v[i].src, 1'b0, v[i].imm, 5'(i));
            in_valid = 1'b1;
            tick();
            checks++;
            if ({out_valid, result, ovf, zero} !==
                {1'b1, v[i].exp_res, v[i].exp_ovf, (v[i].exp_res == 32'h0)}) begin
                failures++;
                $display("FAIL op_%0d: valid=%0b result=%h ovf=%0b zero=%0b want result=%h ovf=%0b",
                         v[i].op, out_valid, result, ovf, zero, v[i].exp_res, v[i].exp_ovf);
            end
        end
        // Undefined code 13
        drive(4'd13, 32'h1234_5678, 32'h1, 1'b0, 1'b0, 16'h0, 5'd4);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, result, ovf, zero} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL op_undef: valid=%0b result=%h ovf=%0b zero=%0b want 1 0 0 1",
                     out_valid, result, ovf, zero);
        end
    endtask

    task automatic test_mul();
        int bad;
        bad = 0;
        drive(OP_MUL, 32'h0000_1234, 32'h0000_0010, 1'b0, 1'b0, 16'h0, 5'd7);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mul_busy: %0d of 32 cycles lacked busy=1 in_ready=0 out_valid=0", bad);
        end
        checks++;
        if ({out_valid, result, rd_out, busy, ovf} !== {1'b1, 32'h0001_2340, 5'd7, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mul_result: valid=%0b result=%h rd=%0d busy=%0b ovf=%0b want 1 00012340 7 0 0",
                     out_valid, result, rd_out, busy, ovf);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        out_ready = 1'b0;
        drive(OP_SUB, 32'd3, 32'd3, 1'b0, 1'b0, 16'h0, 5'd11);
        in_valid = 1'b1;
        tick();
        checks++;
        if ({out_valid, result, zero, rd_out, in_ready} !== {1'b1, 32'h0, 1'b1, 5'd11, 1'b0}) begin
            failures++;
            $display("FAIL bp_first: valid=%0b result=%h zero=%0b rd=%0d in_ready=%0b want 1 0 1 11 0",
                     out_valid, result, zero, rd_out, in_ready);
        end
        drive(OP_ADD, 32'd1, 32'd2, 1'b0, 1'b0, 16'h0, 5'd12);
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({out_valid, result, zero, rd_out, in_ready} !== {1'b1, 32'h0, 1'b1, 5'd11, 1'b0}) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold: %0d of 3 stalled cycles changed the held output", bad);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: in_ready=%0b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, result, zero, rd_out} !== {1'b1, 32'd3, 1'b0, 5'd12}) begin
            failures++;
            $display("FAIL bp_swap: valid=%0b result=%h zero=%0b rd=%0d want 1 3 0 12",
                     out_valid, result, zero, rd_out);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: out_valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        int bad;
        bad = 0;
        drive(OP_MUL, 32'd9, 32'd9, 1'b0, 1'b0, 16'h0, 5'd5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid, in_ready} !== {1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rstmul_state: busy=%0b out_valid=%0b in_ready=%0b want 0 0 1",
                     busy, out_valid, in_ready);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rstmul_quiet: %0d of 30 cycles showed out_valid or busy", bad);
        end
        drive(OP_ADD, 32'd2, 32'd2, 1'b0, 1'b0, 16'h0, 5'd6);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, result, rd_out} !== {1'b1, 32'd4, 5'd6}) begin
            failures++;
            $display("FAIL rstmul_add: valid=%0b result=%h rd=%0d want 1 4 6", out_valid, result, rd_out);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(OP_ADD, '0, '0, 1'b0, 1'b0, 16'h0, '0);
        test_reset();
        test_add_ovf();
        test_immediate();
        test_ops();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
